// File: rtl/register_bank.sv
// register_bank: register file (r0 hard-wired to 0) with two registered read ports and write-first bypass.
// Serial dump FSM (IDLE/SEND/DONE) is built only when REGISTER_BANK_DUMP_EN is defined.
module register_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] read_addr_a,
    input  logic [ADDR_WIDTH-1:0] read_addr_b,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reg_write,
    output logic [DATA_WIDTH-1:0] data_a,
    output logic [DATA_WIDTH-1:0] data_b,
    input  logic                  dump_start,
    input  logic                  dump_ready,
    output logic                  dump_valid,
    output logic [ADDR_WIDTH-1:0] dump_addr,
    output logic [DATA_WIDTH-1:0] dump_data,
    output logic                  dump_busy,
    output logic                  dump_done
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] registers [DEPTH];
    logic                  wr_en;

    assign wr_en = reg_write && write_address != '0;

    // r0 is never written, so the bypass naturally returns 0 for address 0
    function automatic logic [DATA_WIDTH-1:0] bypass(input logic [ADDR_WIDTH-1:0] addr);
        return (wr_en && write_address == addr) ? write_data : registers[addr];
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) registers[i] <= '0;
        end else if (wr_en) begin
            registers[write_address] <= write_data;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_a <= '0;
            data_b <= '0;
        end else begin
            data_a <= bypass(read_addr_a);
            data_b <= bypass(read_addr_b);
        end
    end

`ifdef REGISTER_BANK_DUMP_EN
    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] next_addr;

    assign next_addr = dump_addr + 1'b1;

    // dump_addr doubles as the beat pointer; dump_valid is high for all of SEND
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            dump_addr  <= '0;
            dump_data  <= '0;
            dump_valid <= 1'b0;
            dump_busy  <= 1'b0;
            dump_done  <= 1'b0;
        end else begin
            dump_done <= 1'b0;
            case (state)
                IDLE: if (dump_start) begin
                    state      <= SEND;
                    dump_addr  <= '0;
                    dump_data  <= bypass('0);
                    dump_valid <= 1'b1;
                    dump_busy  <= 1'b1;
                end
                SEND: if (dump_ready) begin
                    if (&dump_addr) begin
                        state      <= DONE;
                        dump_valid <= 1'b0;
                        dump_busy  <= 1'b0;
                        dump_done  <= 1'b1;
                    end else begin
                        dump_addr <= next_addr;
                        dump_data <= bypass(next_addr);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    logic unused_dump;

    assign unused_dump = ^{dump_start, dump_ready};
    assign dump_valid  = 1'b0;
    assign dump_addr   = '0;
    assign dump_data   = '0;
    assign dump_busy   = 1'b0;
    assign dump_done   = 1'b0;
`endif
endmodule

// File: tb/tb_register_bank.sv
// tb_register_bank: table-driven read/write vectors plus dump sequences, checked through scoreboard queues.
// Dump sequences run when REGISTER_BANK_DUMP_EN is defined; otherwise the dump ports must stay idle.
module tb_register_bank;
    logic        clock = 0;
    logic        reset;
    logic [4:0]  read_addr_a, read_addr_b, write_address;
    logic [31:0] write_data;
    logic        reg_write;
    logic [31:0] data_a, data_b;
    logic        dump_start, dump_ready;
    logic        dump_valid;
    logic [4:0]  dump_addr;
    logic [31:0] dump_data;
    logic        dump_busy, dump_done;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
    } vec_t;

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
    } rd_exp_t;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } beat_t;

    vec_t        vecs [10];
    rd_exp_t     rq [$];
    beat_t       dq [$];
    logic [31:0] mem [32];

    register_bank dut (
        .clock(clock), .reset(reset),
        .read_addr_a(read_addr_a), .read_addr_b(read_addr_b),
        .write_address(write_address), .write_data(write_data), .reg_write(reg_write),
        .data_a(data_a), .data_b(data_b),
        .dump_start(dump_start), .dump_ready(dump_ready),
        .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
        .dump_busy(dump_busy), .dump_done(dump_done)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                        input logic [4:0] ra, input logic [4:0] rb,
                        input logic [31:0] ea, input logic [31:0] eb, input string name);
        rd_exp_t e;
        @(negedge clock);
        reg_write = we; write_address = wa; write_data = wd;
        read_addr_a = ra; read_addr_b = rb;
        rq.push_back('{name, ea, eb});
        if (we && wa != 0) mem[wa] = wd;
        @(posedge clock);
        #1;
        e = rq.pop_front();
        check({e.name, "_a"}, data_a, e.a);
        check({e.name, "_b"}, data_b, e.b);
        reg_write = 0;
    endtask

    task automatic push_beats();
        dq.delete();
        for (int i = 0; i < 32; i++) dq.push_back('{5'(i), mem[i]});
    endtask

    task automatic run_dump(input bit stall, input string tag);
        int          n;
        int          cyc;
        logic [31:0] held;
        beat_t       e;
        @(negedge clock);
        dump_ready = 1; dump_start = 1;
        @(negedge clock);
        dump_start = 0;
        check({tag, "_busy"}, dump_busy, 1);
        n = 0; cyc = 0;
        while (n < 32 && cyc < 300) begin
            if (stall && dump_valid && dump_addr == 2) begin
                stall = 0;
                held = dump_data;
                dump_ready = 0;
                reg_write = 1; write_address = 2; write_data = 32'h12345678;
                mem[2] = 32'h12345678;
                for (int k = 0; k < 3; k++) begin
                    @(negedge clock);
                    reg_write = (k == 0); write_address = 20; write_data = 32'h20202020;
                    if (k == 0) mem[20] = 32'h20202020;
                    check({tag, "_stall_addr"}, dump_addr, 2);
                    check({tag, "_stall_data"}, dump_data, held);
                    check({tag, "_stall_valid"}, dump_valid, 1);
                end
                reg_write = 0;
                dump_ready = 1;
            end
            dump_start = (n == 3);
            if (dump_valid && dump_ready) begin
                e = dq.pop_front();
                check({tag, "_beat_addr"}, dump_addr, e.addr);
                check({tag, "_beat_data"}, dump_data, e.data);
                n++;
            end
            @(negedge clock);
            cyc++;
        end
        dump_start = 0;
        checks++;
        if (n < 32) begin
            errors++;
            $display("FAIL %s_timeout: got %0d beats expected 32", tag, n);
        end
        check({tag, "_done"}, dump_done, 1);
        check({tag, "_done_valid"}, dump_valid, 0);
        check({tag, "_done_busy"}, dump_busy, 0);
        @(negedge clock);
        check({tag, "_done_drop"}, dump_done, 0);
        check({tag, "_idle_valid"}, dump_valid, 0);
    endtask

    initial begin
        vecs[0] = '{0,  5'd0, 32'h0,        5'd3,  5'd0,  32'h0,        32'h0};
        vecs[1] = '{1,  5'd1, 32'h0000000A, 5'd1,  5'd2,  32'h0000000A, 32'h0};
        vecs[2] = '{1,  5'd0, 32'hDEADBEEF, 5'd1,  5'd0,  32'h0000000A, 32'h0};
        vecs[3] = '{1,  5'd5, 32'hFFFFFFFB, 5'd5,  5'd1,  32'hFFFFFFFB, 32'h0000000A};
        vecs[4] = '{0,  5'd2, 32'h11111111, 5'd2,  5'd5,  32'h0,        32'hFFFFFFFB};
        vecs[5] = '{1, 5'd31, 32'h80000001, 5'd31, 5'd31, 32'h80000001, 32'h80000001};
        vecs[6] = '{1,  5'd1, 32'h55AA55AA, 5'd1,  5'd31, 32'h55AA55AA, 32'h80000001};
        vecs[7] = '{1,  5'd2, 32'hCAFEF00D, 5'd0,  5'd1,  32'h0,        32'h55AA55AA};
        vecs[8] = '{0,  5'd0, 32'h0,        5'd2,  5'd0,  32'hCAFEF00D, 32'h0};
        vecs[9] = '{1, 5'd30, 32'h1E1E1E1E, 5'd29, 5'd30, 32'h0,        32'h1E1E1E1E};
        for (int i = 0; i < 32; i++) mem[i] = 0;
        reset = 1; reg_write = 0; write_address = 0; write_data = 0;
        read_addr_a = 0; read_addr_b = 0; dump_start = 0; dump_ready = 0;
        repeat (2) @(negedge clock);
        check("rst_data_a", data_a, 0);
        check("rst_dump_valid", dump_valid, 0);
        check("rst_dump_busy", dump_busy, 0);
        reset = 0;
        for (int i = 0; i < 10; i++)
            step(vecs[i].we, vecs[i].wa, vecs[i].wd, vecs[i].ra, vecs[i].rb,
                 vecs[i].ea, vecs[i].eb, $sformatf("vec%0d", i));
        // asynchronous reset in mid-cycle, away from any clock edge
        @(negedge clock);
        #2 reset = 1;
        #1;
        check("async_rst_a", data_a, 0);
        check("async_rst_b", data_b, 0);
        #1 reset = 0;
        for (int i = 0; i < 32; i++) mem[i] = 0;
        step(0, 0, 0, 5'd1, 5'd30, 32'h0, 32'h0, "post_rst");
        step(1, 5'd5, 32'hFFFFFFFB, 5'd5, 5'd0, 32'hFFFFFFFB, 32'h0, "w5");
        step(1, 5'd2, 32'h22222222, 5'd2, 5'd5, 32'h22222222, 32'hFFFFFFFB, "w2");
        step(1, 5'd31, 32'h31313131, 5'd0, 5'd31, 32'h0, 32'h31313131, "w31");
`ifdef REGISTER_BANK_DUMP_EN
        push_beats();
        run_dump(0, "dump1");
        push_beats();
        dq[20].data = 32'h20202020;
        run_dump(1, "dump2");
        step(0, 0, 0, 5'd2, 5'd20, 32'h12345678, 32'h20202020, "after_dump");
        begin
            int cyc;
            bit done_seen;
            @(negedge clock);
            dump_ready = 1; dump_start = 1;
            @(negedge clock);
            dump_start = 0;
            cyc = 0;
            while (!(dump_valid && dump_addr == 10) && cyc < 100) begin
                @(negedge clock);
                cyc++;
            end
            checks++;
            if (cyc >= 100) begin
                errors++;
                $display("FAIL abort_reach: got addr %0d expected 10", dump_addr);
            end
            #2 reset = 1;
            #1;
            check("abort_valid", dump_valid, 0);
            check("abort_busy", dump_busy, 0);
            check("abort_addr", dump_addr, 0);
            check("abort_data", dump_data, 0);
            #1 reset = 0;
            done_seen = 0;
            for (int i = 0; i < 40; i++) begin
                @(negedge clock);
                if (dump_done || dump_valid) done_seen = 1;
            end
            check("abort_no_done", done_seen, 0);
        end
`else
        @(negedge clock);
        dump_ready = 1; dump_start = 1;
        @(negedge clock);
        dump_start = 0;
        for (int i = 0; i < 5; i++) begin
            check("off_valid", dump_valid, 0);
            check("off_busy", dump_busy, 0);
            check("off_done", dump_done, 0);
            @(negedge clock);
        end
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/register_bank.md
REGISTER_BANK -- requirements
Module: register_bank

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32: register and data-port width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: address width; DEPTH = 2**ADDR_WIDTH registers.
REQ-003 SHALL have port clock  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: asynchronous, active-high reset.
REQ-005 SHALL have ports read_addr_a / read_addr_b  input  ADDR_WIDTH: read port A/B addresses.
REQ-006 SHALL have port write_address  input  ADDR_WIDTH: write address.
REQ-007 SHALL have port write_data  input  DATA_WIDTH: write data.
REQ-008 SHALL have port reg_write  input  1: 1 = write this edge, 0 = no write.
REQ-009 SHALL have ports data_a / data_b  output  DATA_WIDTH: registered read data.
REQ-010 SHALL have port dump_start  input  1: request a serial dump of all registers.
REQ-011 SHALL have port dump_ready  input  1: consumer (UART framer) accepts the current beat.
REQ-012 SHALL have ports dump_valid  output  1, dump_addr  output  ADDR_WIDTH, dump_data  output  DATA_WIDTH: current dump beat.
REQ-013 SHALL have ports dump_busy  output  1 (dump in progress) and dump_done  output  1 (one-cycle completion pulse).

Function
REQ-014 Write: on a rising edge with reg_write=1 and write_address!=0, registers[write_address] <= write_data.
REQ-015 Register 0 SHALL always read 0; writes to address 0 are discarded.
REQ-016 Reads: latency 1; after each edge data_a/data_b = registers[read_addr_a/b], including any write committed on that same edge (write-first bypass).
REQ-017 Dump FSM states IDLE, SEND, DONE; leaves IDLE only on dump_start=1 sampled in IDLE; dump_start in SEND/DONE is ignored.
REQ-018 IDLE->SEND edge: pointer <= 0, dump_addr <= 0, dump_data <= registers[0] (write-first), dump_valid <= 1, dump_busy <= 1.
REQ-019 In SEND, dump_addr/dump_data SHALL be held stable while dump_valid=1 and dump_ready=0, irrespective of later writes to that register.
REQ-020 Transfer = dump_valid & dump_ready at an edge; pointer < DEPTH-1: pointer+1, reload dump_addr/dump_data (write-first) with no idle cycle; pointer = DEPTH-1: -> DONE.
REQ-021 DONE lasts exactly one cycle: dump_valid=0, dump_busy=0, dump_done=1; then IDLE with dump_done=0.
REQ-022 Register writes and port-A/B reads SHALL operate normally during a dump; beats for registers not yet loaded reflect those writes.

Reset
REQ-023 reset=1 SHALL immediately, without a clock edge, clear all registers, data_a, data_b, dump_data, dump_addr, dump_valid, dump_busy, dump_done to 0 and force the FSM to IDLE.
REQ-024 Reset asserted mid-dump SHALL abort the dump; no dump_done pulse is produced.

Configuration
REQ-025 Macro REGISTER_BANK_DUMP_EN defined: dump FSM and ports behave per REQ-017..REQ-022.
REQ-026 Macro REGISTER_BANK_DUMP_EN undefined: no dump logic synthesised; dump_valid, dump_busy, dump_done, dump_addr, dump_data tied to 0; dump_start and dump_ready ignored; ports still present.

Verification (defaults DATA_WIDTH=32, ADDR_WIDTH=5, macro defined unless noted)
REQ-027 Release reset, read_addr_a=3 -> data_a=0x00000000 after next edge.
REQ-028 reg_write=1, write_address=1, write_data=0x0000000A, read_addr_a=1 on same edge -> data_a=0x0000000A after that edge.
REQ-029 Write 0xDEADBEEF to address 0, read_addr_b=0 -> data_b=0x00000000.
REQ-030 r5=0xFFFFFFFB, dump_ready=1, pulse dump_start -> 32 consecutive beats, dump_addr 0..31, beat 5 data 0xFFFFFFFB, dump_done high exactly one cycle after beat 31 transfer.
REQ-031 dump_ready=0 for 3 cycles at beat 2 while writing 0x12345678 to r2 -> dump_addr=2, dump_data unchanged for 3 cycles, no beat lost or duplicated.
REQ-032 Assert reset at beat 10 -> dump_valid=0, dump_busy=0 immediately, no dump_done; macro undefined: dump_start pulse -> dump_valid remains 0.
